frame_config_loader: RTL

- Frame-based configuration loader upstream of the fabric's switch matrices and their configuration latches.
- Accepts a 32-bit word stream and synchronises on a sync word.
- Decodes frame headers, then drives FrameData plus a one-hot per-frame FrameStrobe for a selected column.
- Tiles with zero config bits, such as pure wire-loopback terminal matrices, ignore their strobes; the loader is common to all columns.

---
 rtl/frame_config_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/frame_config_loader.sv
// Frame-based configuration loader: syncs on a sync word, decodes frame headers and
// presents FrameData followed one cycle later by a one-hot FrameStrobe for the selected column.
module frame_config_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 16,
  parameter int unsigned StrobeGap       = 2,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [FrameBitsPerRow-1:0]    FrameData,
  output logic [$clog2(NumColumns)-1:0] FrameCol,
  output logic [MaxFramesPerCol-1:0]    FrameStrobe,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Err
);

  localparam int unsigned ColW = $clog2(NumColumns);
  localparam int unsigned IdxW = $clog2(MaxFramesPerCol);
  localparam int unsigned GapW = $clog2(StrobeGap + 2);

  typedef enum logic [1:0] {StIdle, StHeader, StData, StErr} state_e;

  state_e                     state_q, state_d;
  logic [ColW-1:0]            col_q, col_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [15:0]                rem_q, rem_d;
  logic [GapW-1:0]            gap_q, gap_d;
  logic                       pend_q, pend_d;
  logic [IdxW-1:0]            pend_idx_q, pend_idx_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [ColW-1:0]            fcol_q, fcol_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic        xfer;
  logic        is_sync;
  logic [7:0]  hdr_col;
  logic [7:0]  hdr_first;
  logic [15:0] hdr_count;
  logic [16:0] hdr_end;
  logic        hdr_bad;

  // Header field decode and range check; the end-frame sum is 17 bits so it cannot wrap.
  always_comb begin
    hdr_col   = s_data[31:24];
    hdr_first = s_data[23:16];
    hdr_count = s_data[15:0];
    hdr_end   = {9'd0, hdr_first} + {1'b0, hdr_count};
    hdr_bad   = (32'(hdr_col) >= NumColumns) || (hdr_end > 17'(MaxFramesPerCol));
    is_sync   = (s_data == SyncWord);
  end

  // Ready: header and data words wait for the latch settle gap; IDLE/ERR always accept.
  always_comb begin
    s_ready = 1'b1;
    if (state_q == StHeader || state_q == StData) s_ready = (gap_q == '0);
    xfer = s_valid && s_ready;
  end

  // Next-state logic; strobe is issued one cycle after the data word lands.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    gap_d      = (gap_q != '0) ? gap_q - GapW'(1) : '0;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    data_d     = data_q;
    fcol_d     = fcol_q;
    strobe_d   = pend_q ? (MaxFramesPerCol'(1) << pend_idx_q) : '0;
    done_d     = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (xfer && is_sync) begin
          state_d = StHeader;
          err_d   = 1'b0;
        end
      end
      StHeader: begin
        if (xfer) begin
          if (hdr_count == 16'd0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (hdr_bad) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            col_d   = ColW'(hdr_col);
            idx_d   = IdxW'(hdr_first);
            rem_d   = hdr_count;
            state_d = StData;
          end
        end
      end
      StData: begin
        // A sync pattern here is ordinary frame data.
        if (xfer) begin
          data_d     = FrameBitsPerRow'(s_data);
          fcol_d     = col_q;
          gap_d      = GapW'(StrobeGap + 1);
          pend_d     = 1'b1;
          pend_idx_d = idx_q;
          idx_d      = idx_q + IdxW'(1);
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = StHeader;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any pending strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      col_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      data_q     <= '0;
      fcol_q     <= '0;
      strobe_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      data_q     <= data_d;
      fcol_q     <= fcol_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    FrameData   = data_q;
    FrameCol    = fcol_q;
    FrameStrobe = strobe_q;
    Done        = done_q;
    Err         = err_q;
    Busy        = (state_q == StHeader) || (state_q == StData);
  end

endmodule
